// File: rtl/residue_reader_luma16x16_pkg.sv
// residue_reader_luma16x16_pkg: shared intra mode codes, reader states, beat tag type and 4x4 block position helper
package residue_reader_luma16x16_pkg;
  localparam logic [2:0] MODE_V = 3'd0;
  localparam logic [2:0] MODE_H = 3'd1;
  localparam logic [2:0] MODE_DC = 3'd2;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, REJ} state_t;
  typedef struct packed {
    logic [1:0] y;
    logic [1:0] x;
  } blk_pos_t;
  typedef struct packed {
    logic        last;
    logic [3:0]  blk;
    logic [1:0]  row;
    logic [31:0] data;
  } beat_t;
  function automatic blk_pos_t blk_pos(input logic [3:0] b);
    return '{y: {b[3], b[1]}, x: {b[2], b[0]}};
  endfunction
endpackage

// File: rtl/residue_reader_luma16x16_if.sv
// residue_reader_luma16x16_if: request, residue memory read and transform output bus of the macroblock reader
interface residue_reader_luma16x16_if #(parameter int AW = 14);
  logic          req_valid;
  logic          req_ready;
  logic [8:0]    req_mbnumber;
  logic [2:0]    req_mode;
  logic [AW-1:0] mem_addr;
  logic          mem_rd;
  logic [31:0]   mem_rdata;
  logic          out_valid;
  logic          out_ready;
  logic [31:0]   out_data;
  logic [3:0]    out_blk;
  logic [1:0]    out_row;
  logic          out_last;
  logic [2:0]    out_mode;
  logic          err;
  modport master (
    input  req_valid, req_mbnumber, req_mode, mem_rdata, out_ready,
    output req_ready, mem_addr, mem_rd, out_valid, out_data, out_blk, out_row, out_last, out_mode, err
  );
  modport slave (
    output req_valid, req_mbnumber, req_mode, mem_rdata, out_ready,
    input  req_ready, mem_addr, mem_rd, out_valid, out_data, out_blk, out_row, out_last, out_mode, err
  );
endinterface

// File: rtl/residue_reader_luma16x16_fifo2_tagged.sv
// fifo2_tagged: two-entry fall-through FIFO of tagged residue beats, empty push bypasses straight to the output
module fifo2_tagged
  import residue_reader_luma16x16_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       push,
  input  beat_t      in_beat,
  input  logic       ready,
  output logic       valid,
  output logic       pop,
  output beat_t      out_beat,
  output logic [1:0] occ
);
  beat_t head_q, head_d, tail_q, tail_d;
  logic [1:0] cnt_q, cnt_d;
  always_comb begin
    valid = cnt_q != 2'd0 || push;
    pop = valid && ready;
    out_beat = cnt_q != 2'd0 ? head_q : (push ? in_beat : '0);
    cnt_d = cnt_q + {1'b0, push} - {1'b0, pop};
    head_d = pop ? (cnt_q == 2'd2 ? tail_q : in_beat) : (cnt_q == 2'd0 ? in_beat : head_q);
    tail_d = push ? in_beat : tail_q;
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
      head_q <= '0;
      tail_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      head_q <= head_d;
      tail_q <= tail_d;
    end
  end
  assign occ = cnt_q;
endmodule

// File: rtl/residue_reader_luma16x16.sv
// residue_reader_luma16x16: streams one 16x16 luma residue MB from frame memory as 64 4x4-block row beats
module residue_reader_luma16x16
  import residue_reader_luma16x16_pkg::*;
#(
  parameter int WIDTH = 256,
  parameter int HEIGHT = 256
) (
  input logic                       clk,
  input logic                       reset,
  residue_reader_luma16x16_if.master bus
);
  localparam int unsigned MBS_X = WIDTH / 16;
  localparam int unsigned NUM_MB = MBS_X * (HEIGHT / 16);
  localparam int unsigned W4 = WIDTH / 4;
  localparam int AW = $clog2(WIDTH * HEIGHT / 4);
  state_t state_q, state_d;
  logic [5:0] rd_cnt_q, rd_cnt_d, idx_q, idx_d;
  logic [8:0] mbx_q, mbx_d, mby_q, mby_d;
  logic [2:0] mode_q, mode_d;
  logic rv_q, rv_d, pop, credit;
  logic [1:0] occ;
  logic [AW-1:0] y_a;
  blk_pos_t pos;
  beat_t in_beat, head;
  assign pos = blk_pos(rd_cnt_q[5:2]);
  assign y_a = AW'({mby_q, 4'b0}) + AW'({pos.y, 2'b0}) + AW'(rd_cnt_q[1:0]);
  assign bus.mem_addr = y_a * AW'(W4) + AW'({mbx_q, 2'b0}) + AW'(pos.x);
  assign credit = {1'b0, rv_q} + occ < 2'd2 + {1'b0, pop};
  assign bus.mem_rd = state_q == RUN && credit;
  assign bus.req_ready = state_q == IDLE;
  assign bus.err = state_q == REJ;
  assign bus.out_mode = mode_q;
  assign in_beat = '{last: idx_q == 6'd63, blk: idx_q[5:2], row: idx_q[1:0], data: bus.mem_rdata};
  fifo2_tagged u_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (rv_q),
    .in_beat  (in_beat),
    .ready    (bus.out_ready),
    .valid    (bus.out_valid),
    .pop      (pop),
    .out_beat (head),
    .occ      (occ)
  );
  assign bus.out_data = head.data;
  assign bus.out_blk = head.blk;
  assign bus.out_row = head.row;
  assign bus.out_last = head.last;
  always_comb begin
    state_d = state_q;
    rd_cnt_d = rd_cnt_q;
    mbx_d = mbx_q;
    mby_d = mby_q;
    mode_d = mode_q;
    rv_d = bus.mem_rd;
    idx_d = rd_cnt_q;
    case (state_q)
      IDLE: begin
        if (bus.req_valid && 32'(bus.req_mbnumber) >= NUM_MB) state_d = REJ;
        else if (bus.req_valid) begin
          state_d = RUN;
          rd_cnt_d = '0;
          mbx_d = 9'(32'(bus.req_mbnumber) % MBS_X);
          mby_d = 9'(32'(bus.req_mbnumber) / MBS_X);
          mode_d = bus.req_mode;
        end
      end
      RUN: begin
        rd_cnt_d = bus.mem_rd ? rd_cnt_q + 6'd1 : rd_cnt_q;
        state_d = bus.mem_rd && rd_cnt_q == 6'd63 ? DRAIN : RUN;
      end
      DRAIN: state_d = pop && head.last ? IDLE : DRAIN;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      rd_cnt_q <= '0;
      idx_q <= '0;
      mbx_q <= '0;
      mby_q <= '0;
      mode_q <= '0;
      rv_q <= 1'b0;
    end else begin
      state_q <= state_d;
      rd_cnt_q <= rd_cnt_d;
      idx_q <= idx_d;
      mbx_q <= mbx_d;
      mby_q <= mby_d;
      mode_q <= mode_d;
      rv_q <= rv_d;
    end
  end
endmodule

// File: tb/tb_residue_reader_luma16x16.sv
// tb_residue_reader_luma16x16: randomized self-checking bench against a frame-memory and scan-order reference model
module tb_residue_reader_luma16x16;
  import residue_reader_luma16x16_pkg::*;
  localparam int WIDTH = 256;
  localparam int HEIGHT = 256;
  localparam int AW = 14;
  localparam int MBS_X = WIDTH / 16;
  localparam int NUM_MB = MBS_X * HEIGHT / 16;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int checks = 0;
  int errors = 0;
  logic [31:0] mem [2**AW];
  logic [AW-1:0] addr_log [64];
  always #5 clk = ~clk;
  residue_reader_luma16x16_if #(.AW(AW)) bus ();
  residue_reader_luma16x16 #(.WIDTH(WIDTH), .HEIGHT(HEIGHT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );
  always @(posedge clk) if (bus.mem_rd) bus.mem_rdata <= mem[bus.mem_addr];
  function automatic logic [AW-1:0] ref_addr(input int mb, input int k);
    int b, bx, by, x, y;
    b = k / 4;
    bx = 2 * ((b >> 2) & 1) + (b & 1);
    by = 2 * ((b >> 3) & 1) + ((b >> 1) & 1);
    x = 16 * (mb % MBS_X) + 4 * bx;
    y = 16 * (mb / MBS_X) + 4 * by + k % 4;
    return AW'((y * WIDTH + x) / 4);
  endfunction
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic stream(input int mb, input logic [2:0] mode, input bit rnd, input int stop);
    int rd, bt, c;
    bit held;
    logic [42:0] prev, cur;
    rd = 0;
    bt = 0;
    c = 0;
    held = 1'b0;
    prev = '0;
    @(negedge clk);
    chk("req_ready_idle", bus.req_ready, 1);
    bus.req_valid = 1'b1;
    bus.req_mbnumber = 9'(mb);
    bus.req_mode = mode;
    @(negedge clk);
    bus.req_valid = 1'b0;
    while (bt < 64 && bt < stop && c < 3000) begin
      c++;
      bus.out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      #1;
      cur = {bus.out_valid, bus.out_data, bus.out_blk, bus.out_row, bus.out_last, bus.out_mode};
      if (held) chk("hold_stable", cur, prev);
      if (c == 1) chk("valid_not_yet", bus.out_valid, 0);
      chk("no_err", bus.err, 0);
      if (bus.out_valid && bus.out_ready) begin
        chk("beat_data", bus.out_data, mem[ref_addr(mb, bt)]);
        chk("beat_blk", bus.out_blk, bt / 4);
        chk("beat_row", bus.out_row, bt % 4);
        chk("beat_last", bus.out_last, bt == 63);
        chk("beat_mode", bus.out_mode, mode);
        if (!rnd) chk("beat_cycle", c, bt + 2);
        bt++;
      end
      held = bus.out_valid && !bus.out_ready;
      prev = cur;
      if (bus.mem_rd) begin
        chk("rd_in_range", rd < 64, 1);
        if (rd < 64) begin
          addr_log[rd] = bus.mem_addr;
          chk("mem_addr", bus.mem_addr, ref_addr(mb, rd));
        end
        if (!rnd) chk("rd_cycle", c, rd + 1);
        rd++;
      end
      chk("outstanding", rd - bt <= 2, 1);
      @(negedge clk);
    end
    if (bt < stop && bt < 64) chk("stream_timeout", bt, 64);
    else if (bt == 64) begin
      #1;
      chk("idle_after", bus.req_ready, 1);
      chk("no_rd_after", bus.mem_rd, 0);
      chk("no_valid_after", bus.out_valid, 0);
      chk("total_reads", rd, 64);
      if (!rnd) chk("last_cycle", c, 65);
    end
  endtask
  task automatic chk_reset_values();
    chk("rst_req_ready", bus.req_ready, 1);
    chk("rst_mem_rd", bus.mem_rd, 0);
    chk("rst_mem_addr", bus.mem_addr, 0);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_out_data", bus.out_data, 0);
    chk("rst_out_blk", bus.out_blk, 0);
    chk("rst_out_row", bus.out_row, 0);
    chk("rst_out_last", bus.out_last, 0);
    chk("rst_out_mode", bus.out_mode, 0);
    chk("rst_err", bus.err, 0);
  endtask
  initial begin
    for (int i = 0; i < 2**AW; i++) mem[i] = $urandom;
    bus.req_valid = 1'b0;
    bus.req_mbnumber = '0;
    bus.req_mode = '0;
    bus.out_ready = 1'b1;
    #1;
    chk_reset_values();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    stream(0, MODE_V, 1'b0, 64);
    chk("mb0_addr1", addr_log[1], 64);
    chk("mb0_addr4", addr_log[4], 1);
    chk("mb0_addr5", addr_log[5], 65);
    stream(17, MODE_DC, 1'b0, 64);
    chk("mb17_addr0", addr_log[0], 1028);
    chk("mb17_addr4", addr_log[4], 1029);
    chk("mb17_addr8", addr_log[8], 1284);
    stream($urandom_range(0, NUM_MB - 1), MODE_H, 1'b0, 64);
    stream(NUM_MB - 1, MODE_V, 1'b0, 64);
    for (int i = 0; i < 3; i++) stream($urandom_range(0, NUM_MB - 1), 3'($urandom_range(0, 2)), 1'b1, 64);
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_mbnumber = 9'd300;
    bus.req_mode = MODE_DC;
    @(negedge clk);
    bus.req_valid = 1'b0;
    #1;
    chk("rej_err", bus.err, 1);
    chk("rej_busy", bus.req_ready, 0);
    chk("rej_no_rd", bus.mem_rd, 0);
    chk("rej_no_valid", bus.out_valid, 0);
    @(negedge clk);
    #1;
    chk("rej_err_done", bus.err, 0);
    chk("rej_ready", bus.req_ready, 1);
    chk("rej_no_rd2", bus.mem_rd, 0);
    chk("rej_no_valid2", bus.out_valid, 0);
    stream($urandom_range(0, NUM_MB - 1), MODE_DC, 1'b0, 20);
    reset = 1'b0;
    #1;
    chk_reset_values();
    @(negedge clk);
    #1;
    chk_reset_values();
    reset = 1'b1;
    stream(5, MODE_H, 1'b0, 64);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
